// File: rtl/pc_gen.sv
// Program-counter generator for the single-cycle MIPS fetch path.
// Sequential PC with a one-cycle redirect bubble, stall, halt and a saturating fetch counter.
module pc_gen #(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             jump,
    input  logic [PC_W-1:0]  jump_addr,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_off,
    input  logic             halt_req,
    output logic [PC_W-1:0]  pc,
    output logic             valid,
    output logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_RUN   = 2'd1,
        S_REDIR = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_BOOT;
            pc_q    <= PC_W'(RESET_PC);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // The branch offset is already PC_W wide, so modular addition performs the sign extension.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                pc_d    = PC_W'(RESET_PC);
            end
            S_RUN: begin
                if (!stall && !halt_req && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (jump) begin
                    state_d = S_REDIR;
                    pc_d    = jump_addr;
                end else if (branch_taken) begin
                    state_d = S_REDIR;
                    pc_d    = pc_q + PC_W'(1) + branch_off;
                end else if (!stall) begin
                    pc_d    = pc_q + PC_W'(1);
                end
            end
            S_REDIR: begin
                state_d = halt_req ? S_HALT : S_RUN;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_comb begin
        pc        = pc_q;
        fetch_cnt = cnt_q;
        valid     = (state_q == S_RUN);
        flush     = (state_q == S_REDIR);
        halted    = (state_q == S_HALT);
    end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance at the default reset PC, and one at 254 with a
// 2-bit counter to cover PC wrap and counter saturation.
module tb_pc_gen;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b1, a_stall = 1'b0, a_jump = 1'b0, a_br = 1'b0, a_halt = 1'b0;
    logic [7:0]  a_jaddr = 8'h00, a_off = 8'h00;
    logic [7:0]  a_pc;
    logic        a_valid, a_flush, a_halted;
    logic [15:0] a_cnt;

    logic        b_rst = 1'b1, b_stall = 1'b0, b_jump = 1'b0, b_br = 1'b0, b_halt = 1'b0;
    logic [7:0]  b_jaddr = 8'h00, b_off = 8'h00;
    logic [7:0]  b_pc;
    logic        b_valid, b_flush, b_halted;
    logic [1:0]  b_cnt;

    int checks = 0;
    int errors = 0;

    pc_gen #(.PC_W(8), .RESET_PC(0), .CNT_W(16)) dut_a (
        .clk(clk), .rst(a_rst), .stall(a_stall), .jump(a_jump), .jump_addr(a_jaddr),
        .branch_taken(a_br), .branch_off(a_off), .halt_req(a_halt),
        .pc(a_pc), .valid(a_valid), .flush(a_flush), .halted(a_halted), .fetch_cnt(a_cnt)
    );

    pc_gen #(.PC_W(8), .RESET_PC(254), .CNT_W(2)) dut_b (
        .clk(clk), .rst(b_rst), .stall(b_stall), .jump(b_jump), .jump_addr(b_jaddr),
        .branch_taken(b_br), .branch_off(b_off), .halt_req(b_halt),
        .pc(b_pc), .valid(b_valid), .flush(b_flush), .halted(b_halted), .fetch_cnt(b_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks pc, valid, flush, halted and fetch_cnt of instance A in one go.
    task automatic chk_a(input string tag, input logic [7:0] pc, input logic v, input logic f,
                         input logic h, input logic [15:0] cnt);
        chk({tag, ".pc"}, 32'(a_pc), 32'(pc));
        chk({tag, ".valid"}, 32'(a_valid), 32'(v));
        chk({tag, ".flush"}, 32'(a_flush), 32'(f));
        chk({tag, ".halted"}, 32'(a_halted), 32'(h));
        chk({tag, ".cnt"}, 32'(a_cnt), 32'(cnt));
        $display("step %-10s pc=%02h valid=%0b flush=%0b halted=%0b cnt=%0d",
                 tag, a_pc, a_valid, a_flush, a_halted, a_cnt);
    endtask

    initial begin
        // Reset and free run
        step();                     chk_a("boot",     8'h00, 0, 0, 0, 0);
        a_rst = 1'b0; step();       chk_a("run0",     8'h00, 1, 0, 0, 0);
        step();                     chk_a("run1",     8'h01, 1, 0, 0, 1);
        step();                     chk_a("run2",     8'h02, 1, 0, 0, 2);
        step();                     chk_a("run3",     8'h03, 1, 0, 0, 3);
        // Jump at pc=3 to 0x40
        a_jump = 1'b1; a_jaddr = 8'h40;
        step();                     chk_a("jredir",   8'h40, 0, 1, 0, 4);
        a_jump = 1'b0;
        step();                     chk_a("jtgt",     8'h40, 1, 0, 0, 4);
        step();                     chk_a("jtgt1",    8'h41, 1, 0, 0, 5);
        // Reach pc=5, then branch by -2
        a_jump = 1'b1; a_jaddr = 8'h05;
        step();                     chk_a("j5redir",  8'h05, 0, 1, 0, 6);
        a_jump = 1'b0;
        step();                     chk_a("j5",       8'h05, 1, 0, 0, 6);
        a_br = 1'b1; a_off = 8'hFE;
        step();                     chk_a("bredir",   8'h04, 0, 1, 0, 7);
        // Requests during REDIR are ignored
        a_jump = 1'b1; a_jaddr = 8'h77; a_stall = 1'b1;
        step();                     chk_a("btgt",     8'h04, 1, 0, 0, 7);
        // Jump beats branch
        a_stall = 1'b0; a_jaddr = 8'h10; a_off = 8'h03;
        step();                     chk_a("jbredir",  8'h10, 0, 1, 0, 8);
        a_jump = 1'b0; a_br = 1'b0;
        step();                     chk_a("jbtgt",    8'h10, 1, 0, 0, 8);
        // Stall two cycles at pc=7
        a_jump = 1'b1; a_jaddr = 8'h07;
        step();                     chk_a("j7redir",  8'h07, 0, 1, 0, 9);
        a_jump = 1'b0;
        step();                     chk_a("s7a",      8'h07, 1, 0, 0, 9);
        a_stall = 1'b1;
        step();                     chk_a("s7b",      8'h07, 1, 0, 0, 9);
        step();                     chk_a("s7c",      8'h07, 1, 0, 0, 9);
        a_stall = 1'b0;
        step();                     chk_a("s8",       8'h08, 1, 0, 0, 10);
        step();                     chk_a("s9",       8'h09, 1, 0, 0, 11);
        // Halt at pc=9, then requests are ignored
        a_halt = 1'b1; a_jump = 1'b1; a_br = 1'b1;
        step();                     chk_a("halt0",    8'h09, 0, 0, 1, 11);
        a_halt = 1'b0;
        step();                     chk_a("halt1",    8'h09, 0, 0, 1, 11);
        step();                     chk_a("halt2",    8'h09, 0, 0, 1, 11);
        a_jump = 1'b0; a_br = 1'b0;
        a_rst = 1'b1;
        step();                     chk_a("hrst",     8'h00, 0, 0, 0, 0);
        a_rst = 1'b0;
        step();                     chk_a("hrun",     8'h00, 1, 0, 0, 0);
        // Redirect beats stall
        a_stall = 1'b1; a_jump = 1'b1; a_jaddr = 8'h20;
        step();                     chk_a("sjredir",  8'h20, 0, 1, 0, 0);
        // halt_req honoured in REDIR
        a_stall = 1'b0; a_jump = 1'b0; a_halt = 1'b1;
        step();                     chk_a("rhalt",    8'h20, 0, 0, 1, 0);
        a_halt = 1'b0; a_rst = 1'b1;
        step();                     chk_a("rhrst",    8'h00, 0, 0, 0, 0);
        a_rst = 1'b0;
        step();                     chk_a("rrun",     8'h00, 1, 0, 0, 0);
        // Reset during REDIR
        a_jump = 1'b1; a_jaddr = 8'h30;
        step();                     chk_a("rredir",   8'h30, 0, 1, 0, 1);
        a_rst = 1'b1;
        step();                     chk_a("redirrst", 8'h00, 0, 0, 0, 0);
        a_rst = 1'b0; a_jump = 1'b0;
        step();                     chk_a("postrst",  8'h00, 1, 0, 0, 0);

        // Instance B: wrap from 254 and counter saturation at 3
        step();
        chk("b.boot.pc", 32'(b_pc), 32'd254);
        b_rst = 1'b0;
        step(); chk("b.r0.pc", 32'(b_pc), 32'd254); chk("b.r0.cnt", 32'(b_cnt), 32'd0);
        step(); chk("b.r1.pc", 32'(b_pc), 32'd255); chk("b.r1.cnt", 32'(b_cnt), 32'd1);
        step(); chk("b.r2.pc", 32'(b_pc), 32'd0);   chk("b.r2.cnt", 32'(b_cnt), 32'd2);
        step(); chk("b.r3.pc", 32'(b_pc), 32'd1);   chk("b.r3.cnt", 32'(b_cnt), 32'd3);
        step(); chk("b.sat.pc", 32'(b_pc), 32'd2);  chk("b.sat.cnt", 32'(b_cnt), 32'd3);
        $display("step b.wrap pc=%02h cnt=%0d", b_pc, b_cnt);
        // Negative branch wrapping below zero: 2+1-4 = 255
        b_br = 1'b1; b_off = 8'hFC;
        step(); chk("b.bneg.pc", 32'(b_pc), 32'd255); chk("b.bneg.flush", 32'(b_flush), 32'd1);
        b_br = 1'b0;
        step(); chk("b.btgt.pc", 32'(b_pc), 32'd255); chk("b.btgt.valid", 32'(b_valid), 32'd1);
        $display("step b.branch pc=%02h valid=%0b", b_pc, b_valid);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter generator for the single-cycle MIPS datapath. It sits directly upstream of the instruction memory/control decode stage and drives that stage's 8-bit word-addressed `pc` input. It advances sequentially, redirects on jump or taken branch with a one-cycle bubble, supports stall and halt, and keeps a saturating fetch counter.

## Interface
Parameters:
- `PC_W`, 8, PC width in bits (word address).
- `RESET_PC`, 0, PC value loaded on reset.
- `CNT_W`, 16, fetch counter width.

Ports:
- `clk`, in, 1, the single clock. All state updates on the rising edge.
- `rst`, in, 1, reset. Synchronous and active-high.
- `stall`, in, 1, hold the current PC this cycle.
- `jump`, in, 1, absolute redirect request.
- `jump_addr`, in, PC_W, jump target.
- `branch_taken`, in, 1, relative redirect request.
- `branch_off`, in, PC_W, signed two's-complement word offset.
- `halt_req`, in, 1, stop fetching until reset.
- `pc`, out, PC_W, current fetch address to the instruction memory.
- `valid`, out, 1, `pc` holds a real fetch this cycle.
- `flush`, out, 1, asserted during the redirect bubble.
- `halted`, out, 1, the block is in HALT.
- `fetch_cnt`, out, CNT_W, number of accepted fetches.

## Operation
- States: BOOT, RUN, REDIR, HALT.
- Reset (`rst`=1 at an edge):
  - state→BOOT, `pc`=RESET_PC, `fetch_cnt`=0.
  - Outputs while in BOOT: `valid`=0, `flush`=0, `halted`=0.
  - Reset has priority over every other input in every state, including mid-REDIR and HALT.
- BOOT: always goes to RUN next cycle with `pc`=RESET_PC. All request inputs are ignored.
- RUN: `valid`=1. Inputs are evaluated with fixed priority halt_req > jump > branch_taken > stall > increment.
  - halt_req → HALT; `pc` held.
  - jump → REDIR; next `pc`=jump_addr.
  - branch_taken → REDIR; next `pc`=pc+1+sext(branch_off), mod 2^PC_W.
  - stall → stay in RUN; `pc` held.
  - otherwise → `pc`=pc+1, mod 2^PC_W. 255 wraps to 0.
- REDIR: lasts exactly one cycle, with `valid`=0 and `flush`=1.
  - Next state is RUN with `pc` unchanged, so the target is fetched on the following cycle.
  - jump, branch_taken and stall are ignored in REDIR.
  - halt_req is honoured: → HALT.
- HALT: `pc` frozen, `valid`=0, `halted`=1. Only `rst` exits.
- Fetch counter:
  - `fetch_cnt` increments at each edge where state=RUN and `stall`=0 and `halt_req`=0.
  - A RUN cycle that issues a jump or branch counts, because that fetch was accepted.
  - Saturates at all-ones with no wrap.
- Branch arithmetic is PC_W-bit modular. Offsets of −128..+127 are legal; there is no overflow flag.

## Timing
- All outputs are registered or state-decoded; there are no combinational input→output paths.
- Reset values: `pc`=RESET_PC, `valid`=0, `flush`=0, `halted`=0, `fetch_cnt`=0.
- Sequential latency: an input sampled at edge N takes effect on `pc` after edge N.
- Redirect penalty: request at edge N; `pc`=target with `valid`=0 after N; `pc`=target with `valid`=1 after N+1; `pc`=target+1 after N+2 if there is no stall.
- Stall is fully transparent: one held cycle per stall-high edge.
- jump together with branch_taken: jump wins. Any redirect together with stall: redirect wins. halt_req with anything: halt wins.

## Test plan
- Reset then 4 free-run cycles:
  - `pc` reads 0 (valid=0), then 0, 1, 2, 3 with valid=1.
  - `fetch_cnt`=4 after the 4th RUN edge.
- Wrap: RESET_PC=254, free run → `pc` 254, 255, 0, 1.
- Jump at pc=3 to 0x40:
  - Next cycle `pc`=0x40, valid=0, flush=1.
  - Then 0x40 valid=1, then 0x41.
- Branch at pc=5 with off=0xFE (−2): target 4 after the bubble. Simultaneous jump to 0x10 plus branch: target 0x10.
- Stall 2 cycles at pc=7: `pc` stays 7 for 3 cycles, then 8; `fetch_cnt` does not advance on the stalled edges.
- halt_req at pc=9:
  - `pc` stays 9, valid=0, halted=1 indefinitely, with jump and branch ignored.
  - `rst` → `pc`=0, halted=0.
- Reset asserted during REDIR: the next state is BOOT and `pc`=RESET_PC.
